// File: rtl/stab_inject_arbiter.sv
// Packet-level round-robin arbiter sharing the single stab injection port among N sources.
// A head flit locks the grant until its tail is accepted; the output flit is registered.
module stab_inject_arbiter #(
  parameter int N           = 4,
  parameter int DW          = 32,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N*DW-1:0] data_i,
  input  logic [N-1:0]    valid_i,
  output logic [N-1:0]    ready_o,
  output logic [DW-1:0]   data_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [N-1:0]    grant_o,
  output logic            busy_o,
  output logic            err_o
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  // Handshake: a flit moves on any edge where valid and ready are both high;
  // valid_o/data_o never change while valid_o & ~ready_i.
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, owner_q, owner_d, win, sel;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    grant_d, cand, stray;
  logic            err_d, gap_q, gap_d, found, slot_free, acc;
  logic [DW-1:0]   sel_data;
  logic [1:0]      sel_type;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  // Type bit DW-2 is set for head (01) and single (11), clear for body/tail.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      cand[k]  = valid_i[k] & data_i[k*DW + DW - 2];
      stray[k] = valid_i[k] & ~data_i[k*DW + DW - 2];
    end
  end

  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!found && cand[(int'(ptr_q) + i) % N]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + i) % N);
      end
    end
  end

  assign sel       = (state_q == LOCK) ? owner_q : win;
  assign sel_data  = data_i[int'(sel)*DW +: DW];
  assign sel_type  = sel_data[DW-1:DW-2];
  assign slot_free = ~valid_o | ready_i;
  assign acc       = |(valid_i & ready_o);
  assign busy_o    = (state_q == LOCK);

  // gap_q blocks arbitration for one cycle after a locked packet ends.
  always_comb begin
    ready_o = '0;
    if (rstn && slot_free && (state_q == LOCK || (found && !gap_q)))
      ready_o[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_o;
    err_d   = err_o;
    gap_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|stray) err_d = 1'b1;
        if (acc) begin
          if (sel_type == 2'b01) begin
            state_d      = LOCK;
            owner_d      = win;
            cnt_d        = CW'(1);
            grant_d      = '0;
            grant_d[win] = 1'b1;
          end else begin
            ptr_d = next_idx(win);
          end
        end
      end
      LOCK: begin
        if (acc) begin
          if (sel_type == 2'b10 || cnt_q == CW'(MAX_PKT_LEN - 1)) begin
            state_d = IDLE;
            ptr_d   = next_idx(owner_q);
            cnt_d   = '0;
            grant_d = '0;
            gap_d   = 1'b1;
            if (sel_type != 2'b10) err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (sel_type[0]) err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_o <= '0;
      err_o   <= 1'b0;
      gap_q   <= 1'b0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_o <= grant_d;
      err_o   <= err_d;
      gap_q   <= gap_d;
      if (acc) begin
        data_o  <= sel_data;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stab_inject_arbiter.sv
// Directed bench for stab_inject_arbiter: default instance plus a MAX_PKT_LEN=4 instance
// sharing the same inputs for the watchdog scenario.
module tb_stab_inject_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam logic [1:0] HD = 2'b01, BD = 2'b00, TL = 2'b10, SG = 2'b11;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    valid_i;
  logic            ready_i;
  logic [N-1:0]    ready_o, grant_o, w_ready_o, w_grant_o;
  logic [DW-1:0]   data_o, w_data_o;
  logic            valid_o, busy_o, err_o, w_valid_o, w_busy_o, w_err_o;

  int              n_checks = 0;
  int              n_fail = 0;
  logic [DW-1:0]   pkt [N][8];
  int              plen [N];
  int              pos [N];
  logic            use_w;
  logic [N-1:0]    acc_s;
  logic            hs_s;
  logic [DW-1:0]   hsd_s;

  always #5 clk = ~clk;

  stab_inject_arbiter #(.N(N), .DW(DW), .MAX_PKT_LEN(64)) dut (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .grant_o(grant_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  stab_inject_arbiter #(.N(N), .DW(DW), .MAX_PKT_LEN(4)) dut_w (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .ready_o(w_ready_o),
    .data_o(w_data_o), .valid_o(w_valid_o), .ready_i(ready_i), .grant_o(w_grant_o),
    .busy_o(w_busy_o), .err_o(w_err_o)
  );

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int p);
    return {t, 30'(p)};
  endfunction

  task automatic drive_srcs();
    for (int k = 0; k < N; k++) begin
      if (pos[k] < plen[k]) begin
        valid_i[k]           = 1'b1;
        data_i[k*DW +: DW]   = pkt[k][pos[k]];
      end else begin
        valid_i[k]           = 1'b0;
        data_i[k*DW +: DW]   = '0;
      end
    end
  endtask

  // One clock: sample handshakes before the edge, advance source pointers after it.
  task automatic step();
    #1;
    acc_s = valid_i & (use_w ? w_ready_o : ready_o);
    hs_s  = valid_o & ready_i;
    hsd_s = data_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (acc_s[k]) pos[k]++;
    drive_srcs();
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    valid_i = '0;
    data_i  = '0;
    ready_i = 1'b1;
    for (int k = 0; k < N; k++) begin plen[k] = 0; pos[k] = 0; end
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    valid_i = '1;
    for (int k = 0; k < N; k++) data_i[k*DW +: DW] = mk(HD, k);
    #2;
    n_checks++; if (ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", ready_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_o); end
    n_checks++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
    @(posedge clk);
    #1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_edge: got %b expected 0", valid_o); end
    valid_i = '0;
  endtask

  task automatic test_single_source();
    do_reset();
    pkt[0][0] = mk(HD, 'h100);
    for (int j = 1; j < 4; j++) pkt[0][j] = mk(BD, 'h100 + j);
    pkt[0][4] = mk(TL, 'h104);
    plen[0] = 5;
    drive_srcs();
    #1;
    n_checks++; if (ready_o !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", ready_o); end
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 5) begin
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid c=%0d: got %b expected 1", c, valid_o); end
        n_checks++; if (data_o !== pkt[0][c-1]) begin n_fail++; $display("FAIL single_data c=%0d: got %h expected %h", c, data_o, pkt[0][c-1]); end
        n_checks++; if (grant_o !== ((c < 5) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL single_grant c=%0d: got %b", c, grant_o); end
        n_checks++; if (busy_o !== (c < 5)) begin n_fail++; $display("FAIL single_busy c=%0d: got %b expected %b", c, busy_o, c < 5); end
      end else begin
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %b expected 0", valid_o); end
      end
    end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", err_o); end
  endtask

  task automatic test_all_sources();
    logic [DW-1:0] exp_d;
    do_reset();
    for (int k = 0; k < N; k++) begin
      pkt[k][0] = mk(HD, k*16);
      pkt[k][1] = mk(BD, k*16 + 1);
      pkt[k][2] = mk(TL, k*16 + 2);
      plen[k]   = 3;
    end
    drive_srcs();
    // Packets occupy edges 4m+1..4m+3; edge 4m+4 is the boundary bubble.
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c % 4 == 0) begin
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL all_bubble c=%0d: got %b expected 0", c, valid_o); end
      end else begin
        exp_d = pkt[(c-1)/4][(c-1)%4];
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL all_valid c=%0d: got %b expected 1", c, valid_o); end
        n_checks++; if (data_o !== exp_d) begin n_fail++; $display("FAIL all_data c=%0d: got %h expected %h", c, data_o, exp_d); end
      end
    end
    // Pointer must wrap to 0: src0 beats src3 when both offer singles.
    for (int k = 0; k < N; k++) begin plen[k] = 0; pos[k] = 0; end
    pkt[0][0] = mk(SG, 'h0AA);
    pkt[3][0] = mk(SG, 'h3AA);
    plen[0] = 1;
    plen[3] = 1;
    drive_srcs();
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL all_last_bubble: got %b expected 0", valid_o); end
    step();
    n_checks++; if (data_o !== pkt[0][0]) begin n_fail++; $display("FAIL all_ptr_wrap: got %h expected %h", data_o, pkt[0][0]); end
    step();
    n_checks++; if (data_o !== pkt[3][0]) begin n_fail++; $display("FAIL all_ptr_next: got %h expected %h", data_o, pkt[3][0]); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL all_err: got %b expected 0", err_o); end
  endtask

  task automatic test_single_flits();
    int src;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      pkt[1][j] = mk(SG, 'h100 + j);
      pkt[3][j] = mk(SG, 'h300 + j);
    end
    plen[1] = 4;
    plen[3] = 4;
    drive_srcs();
    for (int c = 1; c <= 8; c++) begin
      step();
      src = (c % 2 == 1) ? 1 : 3;
      n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL sgl_valid c=%0d: got %b expected 1", c, valid_o); end
      n_checks++; if (data_o !== pkt[src][(c-1)/2]) begin n_fail++; $display("FAIL sgl_data c=%0d: got %h expected %h", c, data_o, pkt[src][(c-1)/2]); end
      n_checks++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL sgl_grant c=%0d: got %b expected 0000", c, grant_o); end
    end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL sgl_err: got %b expected 0", err_o); end
  endtask

  task automatic test_ready_toggle();
    int            ndel;
    logic          held;
    logic [DW-1:0] hd;
    do_reset();
    pkt[2][0] = mk(HD, 'h200);
    for (int j = 1; j < 7; j++) pkt[2][j] = mk(BD, 'h200 + j);
    pkt[2][7] = mk(TL, 'h207);
    plen[2] = 8;
    drive_srcs();
    ndel = 0;
    for (int c = 0; c < 40; c++) begin
      ready_i = (c % 2 == 1);
      held    = valid_o && !ready_i;
      hd      = data_o;
      step();
      if (hs_s) begin
        n_checks++;
        if (ndel >= 8) begin
          n_fail++; $display("FAIL tog_extra: got flit %h beyond 8 delivered", hsd_s);
        end else if (hsd_s !== pkt[2][ndel]) begin
          n_fail++; $display("FAIL tog_data n=%0d: got %h expected %h", ndel, hsd_s, pkt[2][ndel]);
        end
        ndel++;
      end
      if (held) begin
        n_checks++; if (valid_o !== 1'b1 || data_o !== hd) begin n_fail++; $display("FAIL tog_hold c=%0d: got %b/%h expected 1/%h", c, valid_o, data_o, hd); end
      end
    end
    ready_i = 1'b1;
    n_checks++; if (ndel != 8) begin n_fail++; $display("FAIL tog_count: got %0d expected 8", ndel); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL tog_err: got %b expected 0", err_o); end
  endtask

  task automatic test_watchdog();
    do_reset();
    use_w = 1'b1;
    pkt[0][0] = mk(HD, 'h500);
    for (int j = 1; j < 6; j++) pkt[0][j] = mk(BD, 'h500 + j);
    plen[0] = 6;
    pkt[1][0] = mk(HD, 'h510);
    pkt[1][1] = mk(TL, 'h511);
    plen[1] = 2;
    drive_srcs();
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++; if (w_valid_o !== 1'b1) begin n_fail++; $display("FAIL wd_valid c=%0d: got %b expected 1", c, w_valid_o); end
      n_checks++; if (w_data_o !== pkt[0][c-1]) begin n_fail++; $display("FAIL wd_data c=%0d: got %h expected %h", c, w_data_o, pkt[0][c-1]); end
      n_checks++; if (w_err_o !== (c == 4)) begin n_fail++; $display("FAIL wd_err c=%0d: got %b expected %b", c, w_err_o, c == 4); end
    end
    n_checks++; if (w_busy_o !== 1'b0) begin n_fail++; $display("FAIL wd_busy: got %b expected 0", w_busy_o); end
    n_checks++; if (w_grant_o !== 4'b0000) begin n_fail++; $display("FAIL wd_grant_drop: got %b expected 0000", w_grant_o); end
    step();
    n_checks++; if (w_valid_o !== 1'b0) begin n_fail++; $display("FAIL wd_bubble: got %b expected 0", w_valid_o); end
    step();
    n_checks++; if (w_data_o !== pkt[1][0] || w_valid_o !== 1'b1) begin n_fail++; $display("FAIL wd_next_head: got %b/%h expected 1/%h", w_valid_o, w_data_o, pkt[1][0]); end
    n_checks++; if (w_grant_o !== 4'b0010) begin n_fail++; $display("FAIL wd_next_grant: got %b expected 0010", w_grant_o); end
    use_w = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    pkt[0][0] = mk(HD, 'h600);
    pkt[0][1] = mk(BD, 'h601);
    pkt[0][2] = mk(BD, 'h602);
    pkt[0][3] = mk(TL, 'h603);
    plen[0] = 4;
    drive_srcs();
    step();
    step();
    n_checks++; if (busy_o !== 1'b1 || valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got busy %b valid %b expected 1 1", busy_o, valid_o); end
    rstn = 1'b0;
    #1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", valid_o); end
    n_checks++; if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_lock: got busy %b grant %b expected 0 0000", busy_o, grant_o); end
    n_checks++; if (ready_o !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0000", ready_o); end
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    n_checks++; if (ready_o !== 4'b0000) begin n_fail++; $display("FAIL mid_body_ready: got %b expected 0000", ready_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL mid_err_pre: got %b expected 0", err_o); end
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_body_valid: got %b expected 0", valid_o); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL mid_body_err: got %b expected 1", err_o); end
  endtask

  initial begin
    rstn    = 1'b0;
    valid_i = '0;
    data_i  = '0;
    ready_i = 1'b1;
    use_w   = 1'b0;
    for (int k = 0; k < N; k++) begin plen[k] = 0; pos[k] = 0; end
    test_reset();
    test_single_source();
    test_all_sources();
    test_single_flits();
    test_ready_toggle();
    test_watchdog();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
